// File: rtl/alu_operand_regs.sv
// rtl/alu_operand_regs.sv - ALU operand registers A/B with bus interface, load sequencer and optional flags
// Optional feature macro: ALU_OPREG_FLAGS_EN (carry/zero flag register)
module alu_operand_regs (
  input  logic       clk,
  input  logic       rst,
  inout  wire  [7:0] bus,
  input  logic       ai,
  input  logic       bi,
  input  logic       ao,
  input  logic       bo,
  input  logic       fi,
  input  logic       carry_in,
  input  logic       seq_start,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic       flag_c,
  output logic       flag_z,
  output logic       busy,
  output logic       done,
  output logic       err_contention
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;

  // Exactly one drive request puts a register on the bus; both or neither leave it floating.
  // This is independent of rst so the bus keeps working while the block is held in reset.
  assign bus = (ao && !bo) ? a :
               (bo && !ao) ? b : 8'hzz;

  // Sequencer, operand registers and sticky contention error; busy/done registered with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      a              <= 8'h00;
      b              <= 8'h00;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_contention <= 1'b0;
    end else begin
      if (ao && bo) begin
        err_contention <= 1'b1;
      end
      case (state)
        IDLE: begin
          // Loading a register that is also driving the bus would only reload itself, so hold it.
          if (ai && !ao) begin
            a <= bus;
          end
          if (bi && !bo) begin
            b <= bus;
          end
          if (seq_start) begin
            state <= LOAD_A;
            busy  <= 1'b1;
          end
        end
        LOAD_A: begin
          a     <= bus;
          state <= LOAD_B;
          busy  <= 1'b1;
        end
        LOAD_B: begin
          b     <= bus;
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_OPREG_FLAGS_EN
  // Flag latch: captures ALU carry and a zero test of the bus whenever fi is asserted, in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (fi) begin
      flag_c <= carry_in;
      flag_z <= (bus == 8'h00);
    end
  end
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = fi ^ carry_in;
  assign flag_c = 1'b0;
  assign flag_z = 1'b0;
`endif

endmodule

// File: tb/tb_alu_operand_regs.sv
// tb/tb_alu_operand_regs.sv - randomized self-checking bench for alu_operand_regs
module tb_alu_operand_regs;

  logic       clk = 1'b0;
  logic       rst, ai, bi, ao, bo, fi, carry_in, seq_start;
  logic       tb_en;
  logic [7:0] tb_val;
  wire  [7:0] bus;
  logic [7:0] a, b;
  logic       flag_c, flag_z, busy, done, err_contention;

  int n_cmp = 0;
  int n_bad = 0;

  assign bus = tb_en ? tb_val : 8'hzz;

  always #5 clk = ~clk;

  alu_operand_regs dut (
    .clk(clk), .rst(rst), .bus(bus), .ai(ai), .bi(bi), .ao(ao), .bo(bo),
    .fi(fi), .carry_in(carry_in), .seq_start(seq_start),
    .a(a), .b(b), .flag_c(flag_c), .flag_z(flag_z),
    .busy(busy), .done(done), .err_contention(err_contention)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: phase = cycles into a load sequence (0 none, 1 loading A, 2 loading B, 3 complete)
  logic [7:0] ma, mb;
  logic       mc, mz, merr;
  int         phase = 0;
  bit         mvalid = 1'b0;

  function automatic logic [7:0] exp_bus();
    if (tb_en) return tb_val;
    if (ao && !bo) return ma;
    if (bo && !ao) return mb;
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    logic [7:0] bv;
    bv = exp_bus();
    if (rst) begin
      ma = 8'h00; mb = 8'h00; mc = 1'b0; mz = 1'b0; merr = 1'b0;
      phase = 0; mvalid = 1'b1;
    end else begin
`ifdef ALU_OPREG_FLAGS_EN
      if (fi) begin
        mc = carry_in;
        mz = (bv == 8'h00);
      end
`endif
      if (ao && bo) merr = 1'b1;
      if (phase == 0) begin
        if (ai && !ao) ma = bv;
        if (bi && !bo) mb = bv;
        if (seq_start) phase = 1;
      end else if (phase == 1) begin
        ma = bv; phase = 2;
      end else if (phase == 2) begin
        mb = bv; phase = 3;
      end else begin
        phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("a", a, ma);
      chk("b", b, mb);
      chk("busy", busy, (phase == 1 || phase == 2));
      chk("done", done, (phase == 3));
      chk("err_contention", err_contention, merr);
      chk("flag_c", flag_c, mc);
      chk("flag_z", flag_z, mz);
      if (!tb_en && (ao ^ bo)) chk("bus_drive", bus, ao ? ma : mb);
    end
  end

  task automatic idle_in();
    rst = 1'b0; ai = 1'b0; bi = 1'b0; ao = 1'b0; bo = 1'b0;
    fi = 1'b0; carry_in = 1'b0; seq_start = 1'b0;
    tb_en = 1'b1; tb_val = 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] sel;
    idle_in();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_a", a, 8'h00);
    chk("reset_b", b, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_err", err_contention, 1'b0);
    chk("reset_flags", {flag_c, flag_z}, 2'b00);

    // Direct load of A only
    tb_val = 8'h3C; ai = 1'b1; step(); ai = 1'b0;
    chk("load_a", a, 8'h3C);
    chk("load_a_b", b, 8'h00);

    // Automatic sequence
    seq_start = 1'b1; step(); seq_start = 1'b0;
    chk("seq_busy1", busy, 1'b1);
    chk("seq_done1", done, 1'b0);
    tb_val = 8'h05; step();
    chk("seq_busy2", busy, 1'b1);
    chk("seq_a", a, 8'h05);
    tb_val = 8'hFB; step();
    chk("seq_done3", done, 1'b1);
    chk("seq_busy3", busy, 1'b0);
    chk("seq_b", b, 8'hFB);
    chk("seq_a_keep", a, 8'h05);
    step();
    chk("seq_done4", done, 1'b0);

    // ai ignored while sequencing, then reset aborts a sequence without a done pulse
    seq_start = 1'b1; step(); seq_start = 1'b0;
    tb_val = 8'h11; step();
    ai = 1'b1; tb_val = 8'h77; step(); ai = 1'b0;
    chk("mid_a", a, 8'h11);
    chk("mid_b", b, 8'h77);
    step();
    seq_start = 1'b1; step(); seq_start = 1'b0;
    tb_val = 8'h22; step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("abort_ab", {a, b}, 16'h0000);
    chk("abort_busy_done", {busy, done}, 2'b00);
    step();
    chk("abort_no_done", done, 1'b0);

    // Bus drive, contention, reset not affecting drive
    tb_val = 8'h12; ai = 1'b1; step(); ai = 1'b0;
    tb_en = 1'b0; ao = 1'b1; #1;
    chk("bus_a", bus, 8'h12);
    bi = 1'b1; step(); bi = 1'b0;
    chk("bi_ao_b", b, 8'h12);
    ai = 1'b1; step(); ai = 1'b0;
    chk("ai_ao_hold", a, 8'h12);
    bo = 1'b1; step();
    ao = 1'b0; bo = 1'b0; tb_en = 1'b1;
    chk("contention", err_contention, 1'b1);
    step(); step();
    chk("contention_sticky", err_contention, 1'b1);
    tb_en = 1'b0; ao = 1'b1; rst = 1'b1; #1;
    chk("bus_in_reset", bus, 8'h12);
    step(); rst = 1'b0; ao = 1'b0; tb_en = 1'b1;
    chk("contention_clr", err_contention, 1'b0);

    // Flags
    tb_val = 8'h00; carry_in = 1'b1; fi = 1'b1; step();
`ifdef ALU_OPREG_FLAGS_EN
    chk("flags_set", {flag_c, flag_z}, 2'b11);
`else
    chk("flags_set", {flag_c, flag_z}, 2'b00);
`endif
    tb_val = 8'h01; carry_in = 1'b0; step(); fi = 1'b0;
    chk("flags_clr", {flag_c, flag_z}, 2'b00);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      idle_in();
      rst       = ($urandom_range(0, 49) == 0);
      seq_start = ($urandom_range(0, 7) == 0);
      ai        = ($urandom_range(0, 2) == 0);
      bi        = ($urandom_range(0, 2) == 0);
      fi        = $urandom_range(0, 1);
      carry_in  = $urandom_range(0, 1);
      tb_val    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      sel       = 3'($urandom_range(0, 7));
      if (sel == 3'd0) ao = 1'b1;
      else if (sel == 3'd1) bo = 1'b1;
      else if (sel == 3'd2 && phase == 0) begin
        ao = 1'b1; bo = 1'b1; ai = 1'b0; bi = 1'b0; fi = 1'b0;
      end
      tb_en = !(ao || bo);
      step();
    end

    idle_in();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_regs.md
ALU_OPERAND_REGS -- requirements
Module: alu_operand_regs

Interface
REQ-001 SHALL have ports (clock and reset first):
 - clk  input  1  sole clock; all state updates on rising edge
 - rst  input  1  synchronous reset, active-high
 - bus  inout  8  shared system bus
 - ai  input  1  load A from bus
 - bi  input  1  load B from bus
 - ao  input  1  drive A onto bus
 - bo  input  1  drive B onto bus
 - fi  input  1  latch flags
 - carry_in  input  1  carry from ALU
 - seq_start  input  1  start automatic A-then-B load sequence
 - a  output  8  A register, feeds ALU operand a
 - b  output  8  B register, feeds ALU operand b
 - flag_c  output  1  latched carry
 - flag_z  output  1  latched zero
 - busy  output  1  sequence in progress
 - done  output  1  one-cycle sequence-complete pulse
 - err_contention  output  1  sticky bus-contention error
REQ-002 SHALL have no parameters; all widths fixed at 8 bits.

Function
REQ-003 SHALL implement FSM with states IDLE, LOAD_A, LOAD_B, DONE.
REQ-004 IDLE with ai=1: A <= bus on the edge; with bi=1: B <= bus; both high: both load the same value.
REQ-005 IDLE with seq_start=1: next state LOAD_A; seq_start in any other state is ignored.
REQ-006 LOAD_A: A <= bus on the edge; next state LOAD_B.
REQ-007 LOAD_B: B <= bus on the edge; next state DONE.
REQ-008 DONE: done=1 for exactly this cycle; next state IDLE.
REQ-009 busy=1 in LOAD_A and LOAD_B, 0 otherwise; done=1 only in DONE.
REQ-010 ai and bi SHALL be ignored while FSM is not IDLE.
REQ-011 Bus drive (combinational): ao=1, bo=0 -> bus=A; bo=1, ao=0 -> bus=B; otherwise high-Z.
REQ-012 ao=1 and bo=1 together: bus high-Z; err_contention set on that edge, held until rst.
REQ-013 ai=1 with ao=1 on the same cycle: A reloads its own value (no change); likewise B with bi/bo.
REQ-014 fi=1: flag_c <= carry_in, flag_z <= (bus == 8'h00) on the edge; otherwise flags hold.
REQ-015 fi SHALL be honoured in every FSM state.
REQ-016 Bus value that is high-Z or X when sampled is loaded as-is; no filtering.

Reset
REQ-017 rst=1 on an edge SHALL force: state IDLE, a=8'h00, b=8'h00, flag_c=0, flag_z=0, done=0, busy=0, err_contention=0.
REQ-018 rst SHALL override all inputs, including mid-sequence; an aborted sequence never pulses done.
REQ-019 rst SHALL NOT affect the bus drive; ao/bo remain effective during reset.

Configuration
REQ-020 Macro ALU_OPREG_FLAGS_EN defined: flags register per REQ-014 present.
REQ-021 Macro ALU_OPREG_FLAGS_EN undefined: no flag storage; flag_c=0 and flag_z=0 constantly; fi and carry_in ignored.

Verification
REQ-022 rst, then bus=8'h3C, ai=1 for one cycle -> a=8'h3C, b=8'h00.
REQ-023 seq_start=1 one cycle, bus=8'h05 then 8'hFB -> a=8'h05, b=8'hFB, busy=1 two cycles, done=1 on third cycle only.
REQ-024 Mid-sequence in LOAD_B, assert ai with bus=8'h77 -> a unchanged; then rst -> all outputs zero, no done pulse.
REQ-025 a=8'h12, ao=1 -> bus reads 8'h12; ao=1, bo=1 -> bus=8'hZZ, err_contention=1 and stays 1 until rst.
REQ-026 With ALU_OPREG_FLAGS_EN: bus=8'h00, carry_in=1, fi=1 -> flag_c=1, flag_z=1; bus=8'h01, carry_in=0, fi=1 -> both 0; without macro both stay 0.
